// File: rtl/fetch_stage_if.sv
// fetch_stage_if: signal bundle between the fetch stage and its neighbours
// (next-PC block, hazard unit, decode, instruction memory).
// master = fetch stage side, slave = surrounding pipeline / test side.
interface fetch_stage_if;
   logic        pcen;
   logic [31:0] newpc;
   logic        pcclear;
   logic        halt;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] imem_addr;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        halted;
   logic [15:0] fetch_cnt;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   modport master (
      input  pcen, newpc, pcclear, halt, imem_rdata,
      output pc, imem_addr, if_id_instr, if_id_pc, if_id_pc4, if_id_valid,
             halted, fetch_cnt, stall_cnt, flush_cnt
   );

   modport slave (
      output pcen, newpc, pcclear, halt, imem_rdata,
      input  pc, imem_addr, if_id_instr, if_id_pc, if_id_pc4, if_id_valid,
             halted, fetch_cnt, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: architectural PC, instruction-memory address and IF/ID register.
// BOOT -> RUN -> HALT control; redirect flush beats halt beats stall beats fetch.
// Optional event counters are built when macro FETCH_STATS_EN is defined;
// otherwise the counter outputs are tied to zero.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst_n,
   fetch_stage_if.master bus
);

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
   typedef enum logic [2:0] {ACT_NONE, ACT_FLUSH, ACT_HALT, ACT_STALL, ACT_FETCH} act_t;

   state_t      state_q, state_d;
   act_t        act;

   // p0: architectural PC (fetch address); p1: IF/ID register contents
   logic [31:0] pc_p0;
   logic [31:0] instr_p1;
   logic [31:0] ifpc_p1;
   logic        vld_p1;
   logic        halted_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= BOOT;
      else        state_q <= state_d;
   end

   // Next-state logic: BOOT lasts one cycle, HALT is absorbing, redirect squashes halt
   always_comb begin
      state_d = state_q;
      case (state_q)
         BOOT:    state_d = RUN;
         RUN:     if (!bus.pcclear && bus.halt) state_d = HALT;
         HALT:    state_d = HALT;
         default: state_d = BOOT;
      endcase
   end

   // Output decode: select the action taken at this edge in RUN priority order
   always_comb begin
      act = ACT_NONE;
      if (state_q == RUN) begin
         if (bus.pcclear)    act = ACT_FLUSH;
         else if (bus.halt)  act = ACT_HALT;
         else if (!bus.pcen) act = ACT_STALL;
         else                act = ACT_FETCH;
      end
   end

   // ---- p0: PC register ----
   // PC loads newpc on fetch and on redirect, holds otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_p0 <= RESET_PC;
      end else if (act == ACT_FLUSH || act == ACT_FETCH) begin
         pc_p0 <= bus.newpc;
      end
   end

   // ---- p1: IF/ID register ----
   // IF/ID captures the fetched word, or a NOP bubble on flush/halt
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_p1 <= NOP_WORD;
         ifpc_p1  <= 32'h0000_0000;
         vld_p1   <= 1'b0;
      end else begin
         case (act)
            ACT_FLUSH: begin
               instr_p1 <= NOP_WORD;
               ifpc_p1  <= 32'h0000_0000;
               vld_p1   <= 1'b0;
            end
            ACT_HALT: begin
               instr_p1 <= NOP_WORD;
               vld_p1   <= 1'b0;
            end
            ACT_FETCH: begin
               instr_p1 <= bus.imem_rdata;
               ifpc_p1  <= pc_p0;
               vld_p1   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Halted flag rises on the edge that enters HALT and stays until reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               halted_q <= 1'b0;
      else if (act == ACT_HALT) halted_q <= 1'b1;
   end

   assign bus.pc          = pc_p0;
   assign bus.imem_addr   = pc_p0;
   assign bus.if_id_instr = instr_p1;
   assign bus.if_id_pc    = ifpc_p1;
   assign bus.if_id_pc4   = ifpc_p1 + 32'd4;
   assign bus.if_id_valid = vld_p1;
   assign bus.halted      = halted_q;

`ifdef FETCH_STATS_EN
   logic [15:0] fetch_cnt_q, stall_cnt_q, flush_cnt_q;

   // Event counters advance only on RUN edges and wrap at 16 bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= 16'h0000;
         stall_cnt_q <= 16'h0000;
         flush_cnt_q <= 16'h0000;
      end else begin
         if (act == ACT_FETCH) fetch_cnt_q <= fetch_cnt_q + 16'd1;
         if (act == ACT_STALL) stall_cnt_q <= stall_cnt_q + 16'd1;
         if (act == ACT_FLUSH) flush_cnt_q <= flush_cnt_q + 16'd1;
      end
   end

   assign bus.fetch_cnt = fetch_cnt_q;
   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;
`else
   assign bus.fetch_cnt = 16'h0000;
   assign bus.stall_cnt = 16'h0000;
   assign bus.flush_cnt = 16'h0000;
`endif

endmodule
